// File: rtl/ga_pkg.sv
// Shared defaults and interrupt source indices for the gate-array raster interrupt block.
package ga_pkg;

    localparam int GA_CNT_W     = 6;
    localparam int GA_INT_LINES = 52;
    localparam int GA_VS_DELAY  = 2;
    localparam int GA_LINE_W    = 9;

    localparam int SRC_PERIODIC = 0;
    localparam int SRC_RASTER   = 1;

    // Gate-array register write that resets the periodic counter: D[7:6]=10 with D[4] set.
    function automatic logic is_int_reset_cmd(input logic [7:0] d);
        return (d[7:6] == 2'b10) && d[4];
    endfunction

endpackage

// File: rtl/ga_ce_edge.sv
// CE-qualified edge detector: previous level and edges move only on sample-strobe cycles.
module ga_ce_edge (
    input  logic clk,
    input  logic rst,
    input  logic ce,
    input  logic sig,
    output logic rise,
    output logic fall
);

    logic old;

    always_ff @(posedge clk) begin
        if (rst) begin
            old <= 1'b0;
        end else if (ce) begin
            old <= sig;
        end
    end

    assign rise = ce & ~old &  sig;
    assign fall = ce &  old & ~sig;

endmodule

// File: rtl/ga_raster_int.sv
// Gate-array interrupt generator: periodic HSYNC-count interrupt with VSYNC resync,
// plus an optional raster-line compare interrupt that replaces the periodic one.
module ga_raster_int
    import ga_pkg::*;
#(
    parameter int CNT_W     = GA_CNT_W,
    parameter int INT_LINES = GA_INT_LINES,
    parameter int VS_DELAY  = GA_VS_DELAY,
    parameter int LINE_W    = GA_LINE_W
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              CE,
    input  logic              crtc_hs,
    input  logic              crtc_vs,
    input  logic              WE,
    input  logic [7:0]        D,
    input  logic              pri_we,
    input  logic [LINE_W-1:0] pri_line,
    input  logic              INTack,
    output logic              INT,
    output logic [1:0]        INT_SRC,
    output logic [LINE_W-1:0] line_cnt
);

    localparam int DLY_W = (VS_DELAY > 0) ? $clog2(VS_DELAY + 1) : 1;
    localparam logic [CNT_W-1:0] INT_LINES_C = CNT_W'(INT_LINES);
    localparam logic [DLY_W-1:0] VS_DELAY_C  = DLY_W'(VS_DELAY);

    logic              hs_fall, vs_rise;
    logic              hs_rise_unused, vs_fall_unused;
    logic [CNT_W-1:0]  periodic_cnt, cnt_n;
    logic [DLY_W-1:0]  dly_cnt, dly_n;
    logic [LINE_W-1:0] cmp_line, line_n;
    logic [1:0]        pend_n;
    logic              raster, set0, set1, clr0, clr1;

    ga_ce_edge u_hs_edge (
        .clk  (CLK),
        .rst  (RESET),
        .ce   (CE),
        .sig  (crtc_hs),
        .rise (hs_rise_unused),
        .fall (hs_fall)
    );

    ga_ce_edge u_vs_edge (
        .clk  (CLK),
        .rst  (RESET),
        .ce   (CE),
        .sig  (crtc_vs),
        .rise (vs_rise),
        .fall (vs_fall_unused)
    );

    assign raster = (cmp_line != '0);

    always_comb begin
        cnt_n  = periodic_cnt;
        dly_n  = dly_cnt;
        line_n = line_cnt;
        set0   = 1'b0;
        set1   = 1'b0;
        clr0   = 1'b0;
        clr1   = 1'b0;

        // Clears are applied first so that same-cycle HSYNC steps and set events win.
        if (WE && is_int_reset_cmd(D)) begin
            cnt_n = '0;
            clr0  = 1'b1;
        end

        if (INTack) begin
            if (INT_SRC[SRC_RASTER]) begin
                clr1 = 1'b1;
            end else begin
                clr0 = 1'b1;
                cnt_n[CNT_W-1] = 1'b0;
            end
        end

        if (hs_fall) begin
            cnt_n = cnt_n + 1'b1;
            if (cnt_n == INT_LINES_C) begin
                cnt_n = '0;
                set0  = ~raster;
            end
        end

        // VSYNC resync: after VS_DELAY lines, fire early only if the count is in its upper half.
        if (vs_rise) begin
            dly_n = '0;
        end else if (hs_fall && (dly_cnt < VS_DELAY_C)) begin
            dly_n = dly_cnt + 1'b1;
            if (dly_n == VS_DELAY_C) begin
                if (cnt_n[CNT_W-1] && !raster) begin
                    set0 = 1'b1;
                end
                cnt_n = '0;
            end
        end

        if (vs_rise) begin
            line_n = '0;
        end else if (hs_fall && (line_cnt != '1)) begin
            line_n = line_cnt + 1'b1;
            if (raster && (line_n == cmp_line)) begin
                set1 = 1'b1;
            end
        end

        pend_n[SRC_PERIODIC] = set0 | (INT_SRC[SRC_PERIODIC] & ~clr0);
        pend_n[SRC_RASTER]   = set1 | (INT_SRC[SRC_RASTER]   & ~clr1);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            periodic_cnt <= '0;
            dly_cnt      <= VS_DELAY_C;
            line_cnt     <= '0;
            cmp_line     <= '0;
            INT_SRC      <= '0;
            INT          <= 1'b0;
        end else begin
            periodic_cnt <= cnt_n;
            dly_cnt      <= dly_n;
            line_cnt     <= line_n;
            INT_SRC      <= pend_n;
            INT          <= |pend_n;
            if (pri_we) begin
                cmp_line <= pri_line;
            end
        end
    end

endmodule

// File: doc/ga_raster_int.md
GA_RASTER_INT -- requirements
Module: ga_raster_int

Interface
REQ-001 SHALL have parameter CNT_W, default 6, width of the periodic HSYNC counter.
REQ-002 SHALL have parameter INT_LINES, default 52, HSYNC falls per periodic interrupt (2..2^CNT_W-1).
REQ-003 SHALL have parameter VS_DELAY, default 2, HSYNC falls after VSYNC rise before resync.
REQ-004 SHALL have parameter LINE_W, default 9, width of the raster line counter and compare register.
REQ-005 SHALL have port CLK, in, 1, the only clock; all logic on its rising edge.
REQ-006 SHALL have port RESET, in, 1: synchronous, active-high.
REQ-007 SHALL have port CE, in, 1, sample strobe; sync inputs are sampled only when CE=1.
REQ-008 SHALL have ports crtc_hs and crtc_vs, in, 1 each, CRTC HSYNC and VSYNC.
REQ-009 SHALL have ports WE (in, 1) and D (in, 8), gate-array register write strobe and data.
REQ-010 SHALL have ports pri_we (in, 1) and pri_line (in, LINE_W), load of the raster compare line; 0 disables it.
REQ-011 SHALL have port INTack, in, 1, Z80 interrupt acknowledge.
REQ-012 SHALL have port INT, out, 1, interrupt request.
REQ-013 SHALL have ports INT_SRC (out, 2: bit0 periodic, bit1 raster) and line_cnt (out, LINE_W, current raster line).

Function
REQ-014 SHALL detect an HSYNC fall (old_hs=1, crtc_hs=0) and a VSYNC rise (old_vs=0, crtc_vs=1) only on CE cycles; old_hs and old_vs update only on CE cycles.
REQ-015 SHALL increment the periodic counter on each HSYNC fall; on reaching INT_LINES it SHALL clear to 0 and set pending[0], unless raster mode is active.
REQ-016 SHALL enable raster mode when the compare register is nonzero; pending[0] is then never set by REQ-015 or REQ-017.
REQ-017 SHALL clear the delay counter to 0 on a VSYNC rise. While delay < VS_DELAY, each HSYNC fall increments it; on reaching VS_DELAY it SHALL set pending[0] if counter MSB=1 (subject to REQ-016) and clear the periodic counter. The REQ-015 step is evaluated first in the same cycle.
REQ-018 SHALL clear line_cnt to 0 on a VSYNC rise and increment it on each HSYNC fall, saturating at 2^LINE_W-1 with no wrap.
REQ-019 SHALL set pending[1] when line_cnt is incremented to a value equal to a nonzero compare register.
REQ-020 SHALL, on a WE cycle with D[7:6]=2'b10 and D[4]=1, clear the periodic counter and pending[0] before any same-cycle HSYNC increment; a same-cycle fall therefore leaves the counter at 1. pending[1] is unaffected.
REQ-021 SHALL, on INTack, clear pending[1] if set, else clear pending[0] and the periodic counter MSB; exactly one source is cleared per ack.
REQ-022 SHALL give a new set event priority over a same-cycle ack or write clear of the same bit.
REQ-023 SHALL drive INT = |pending and INT_SRC = pending, both registered; INT rises on the clock edge that ends the detecting CE cycle (latency 1 clock).
REQ-024 SHALL load the compare register from pri_line on pri_we; the new value is effective for compares from the next cycle.

Reset
REQ-025 SHALL, while RESET=1: periodic counter 0, delay counter = VS_DELAY (idle), line_cnt 0, compare register 0, old_hs 0, old_vs 0, pending 0, INT 0, INT_SRC 0.
REQ-026 SHALL treat RESET mid-frame as a full restart; the first HSYNC fall after release counts as 1.

Structure
REQ-027 SHALL place the parameter defaults and INT_SRC bit indices (SRC_PERIODIC=0, SRC_RASTER=1) in a shared package, ga_pkg.
REQ-028 SHALL use one sub-module, ga_ce_edge, a CE-qualified rise/fall detector, instantiated for crtc_hs and crtc_vs.

Verification
REQ-029 SHALL cover: CE every 16 clocks, 104 HSYNC falls, no VSYNC -> INT rises after fall 52 and fall 104, counter 0 each time.
REQ-030 SHALL cover: counter at 40 (MSB=1), VSYNC rise, 2 falls -> INT set at fall 2 and counter 0; repeat with counter 20 -> no INT, counter 0.
REQ-031 SHALL cover: INT pending, INTack pulse -> INT 0 next clock; the next periodic INT not before 52 further falls.
REQ-032 SHALL cover: WE D=8'h90 in the same cycle as an HSYNC fall with counter 30 -> counter 1, pending[0] cleared.
REQ-033 SHALL cover: pri_line=100, VSYNC then 120 falls -> INT_SRC=2'b10 at fall 100 only; no periodic INT at fall 52 or 104.
REQ-034 SHALL cover: both sources pending, two INTack pulses -> INT_SRC 2'b11 -> 2'b01 -> 2'b00; RESET asserted mid-count -> all outputs 0 on the next clock.
